// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: command handshake bundle between a host and the
// shift-register sequencer.
//   cmd_valid / cmd_ready : valid/ready handshake (accept on valid & ready)
//   cmd_op                : 00 hold, 01 shift right, 10 shift left, 11 load
//   cmd_cnt               : shift count (saturates to WIDTH in the sequencer)
//   cmd_fill              : serial fill bit (rotate select when rotate is built in)
//   cmd_data              : parallel load value
// master = host side, slave = sequencer side.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_fill;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: one-command-at-a-time sequencer for a universal shift
// register (hold / shift right / shift left / parallel load).
// Ports:
//   CLK, CLRb : clock (rising edge) and async active-low reset
//   cmd       : command handshake (shift_seq_ctrl_if.slave)
//   abort     : terminate the active shift after the current cycle
//   sr_q      : shift-register contents (rotate feature only)
//   s         : mode select to the register (cmd_op encoding)
//   SDL, SDR  : left / right serial inputs
//   D         : parallel load data
//   busy, done, aborted : status; done is a one-cycle pulse, aborted valid with done
// Optional feature: define SHIFT_SEQ_ROTATE_EN to make cmd_fill = 1 on a
// shift select rotate instead of a constant fill.
// All outputs are registered from the next-state decode.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             CLRb,
  shift_seq_ctrl_if.slave  cmd,
  input  logic             abort,
  input  logic [WIDTH-1:0] sr_q,
  output logic [1:0]       s,
  output logic             SDL,
  output logic             SDR,
  output logic [WIDTH-1:0] D,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_RIGHT = 2'b01;
  localparam logic [1:0] OP_LEFT  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             fill_q, fill_d;
  logic [1:0]       s_q, s_d;
  logic             sdl_q, sdl_d, sdr_q, sdr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             busy_q, done_q, aborted_q, aborted_d, ready_q;
  logic             accept, bit_l, bit_r;

  assign accept = cmd.cmd_valid & ready_q;

  // Serial bit for the cycle after this edge.
`ifdef SHIFT_SEQ_ROTATE_EN
  // Outputs are registered, so the rotate bit is taken from the register
  // value it will hold after this edge: if a shift happens on this edge the
  // bit that will sit at the end is one position further in.
  always_comb begin
    if (state_q == SHIFT) begin
      bit_r = fill_d ? sr_q[1]       : 1'b0;
      bit_l = fill_d ? sr_q[WIDTH-2] : 1'b0;
    end else begin
      bit_r = fill_d ? sr_q[0]       : 1'b0;
      bit_l = fill_d ? sr_q[WIDTH-1] : 1'b0;
    end
  end
`else
  logic sr_unused;
  assign sr_unused = ^sr_q;
  assign bit_r     = fill_d;
  assign bit_l     = fill_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    fill_d    = fill_q;
    aborted_d = 1'b0;
    d_d       = d_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d   = cmd.cmd_op;
        fill_d = cmd.cmd_fill;
        cnt_d  = (cmd.cmd_cnt > CNT_MAX) ? CNT_MAX : cmd.cmd_cnt;
        if (cmd.cmd_op == OP_LOAD) begin
          state_d = LOAD;
          d_d     = cmd.cmd_data;
        end else if (cmd.cmd_op != OP_HOLD && cmd.cmd_cnt != '0) begin
          state_d = SHIFT;
        end else begin
          state_d = DONE;
        end
      end
      LOAD:  state_d = DONE;
      SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    s_d   = OP_HOLD;
    sdl_d = 1'b0;
    sdr_d = 1'b0;
    if (state_d == LOAD) s_d = OP_LOAD;
    if (state_d == SHIFT) begin
      s_d   = op_d;
      sdr_d = (op_d == OP_RIGHT) & bit_r;
      sdl_d = (op_d == OP_LEFT)  & bit_l;
    end
  end

  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_HOLD;
      fill_q    <= 1'b0;
      s_q       <= OP_HOLD;
      sdl_q     <= 1'b0;
      sdr_q     <= 1'b0;
      d_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      fill_q    <= fill_d;
      s_q       <= s_d;
      sdl_q     <= sdl_d;
      sdr_q     <= sdr_d;
      d_q       <= d_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      aborted_q <= aborted_d;
      ready_q   <= (state_d == IDLE);
    end
  end

  assign s             = s_q;
  assign SDL           = sdl_q;
  assign SDR           = sdr_q;
  assign D             = d_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;
  localparam int W  = 8;
  localparam int CW = 4;
`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         CLRb = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] sr_q = '0;
  logic [1:0]   s;
  logic         SDL, SDR, busy, done, aborted;
  logic [W-1:0] D;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_reg = '0;

  shift_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) cif ();

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK(CLK), .CLRb(CLRb), .cmd(cif), .abort(abort), .sr_q(sr_q),
    .s(s), .SDL(SDL), .SDR(SDR), .D(D),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 CLK = ~CLK;

  // Behavioural universal shift register driven by the sequencer.
  always @(posedge CLK) begin
    case (s)
      2'b01:   sr_q <= {SDR, sr_q[W-1:1]};
      2'b10:   sr_q <= {sr_q[W-2:0], SDL};
      2'b11:   sr_q <= D;
      default: sr_q <= sr_q;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register value after n shifts, from plain arithmetic.
  function automatic logic [W-1:0] model(input logic [W-1:0] v, input logic [1:0] op,
                                         input int n, input logic fill);
    int x;
    int r;
    x = int'(v);
    r = x;
    if (op == 2'b01) begin
      if (ROT && fill) r = (x >> n) | (x << (W - n));
      else             r = (x >> n) | (fill ? (255 << (W - n)) : 0);
    end else if (op == 2'b10) begin
      if (ROT && fill) r = (x << n) | (x >> (W - n));
      else             r = (x << n) | (fill ? ((1 << n) - 1) : 0);
    end
    return W'(r & 255);
  endfunction

  // Issue one command and check the whole transaction. Entered and left at a
  // negedge; the last negedge is the IDLE cycle after done.
  task automatic run_cmd(input logic [1:0] op, input int cnt, input logic fill,
                         input logic [W-1:0] data, input int abort_at);
    int  eff;
    int  n;
    int  done_cyc;
    int  t;
    bit  exp_ab;
    bit  rot_mode;
    eff      = (op == 2'b01 || op == 2'b10) ? ((cnt > W) ? W : cnt) : 0;
    n        = eff;
    exp_ab   = 1'b0;
    rot_mode = ROT && fill && (op == 2'b01 || op == 2'b10);
    if (eff > 0 && abort_at >= 1 && abort_at <= eff) begin
      n = abort_at;
      exp_ab = 1'b1;
    end
    done_cyc = (op == 2'b11) ? 2 : n + 1;

    t = 0;
    while (cif.cmd_ready !== 1'b1 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    chk("ready_before_cmd", cif.cmd_ready, 1);

    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_cnt   = CW'(cnt);
    cif.cmd_fill  = fill;
    cif.cmd_data  = data;
    @(posedge CLK);
    #1;
    // Fields must have been captured; scramble them.
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'($urandom);
    cif.cmd_cnt   = CW'($urandom);
    cif.cmd_fill  = 1'($urandom);
    cif.cmd_data  = W'($urandom);

    for (int k = 1; k <= done_cyc; k++) begin
      @(negedge CLK);
      if (k < done_cyc) begin
        chk("done_low", done, 0);
        chk("busy_high", busy, 1);
        chk("ready_low", cif.cmd_ready, 0);
        if (op == 2'b11) begin
          chk("load_s", s, 2'b11);
          chk("load_D", D, data);
        end else begin
          chk("shift_s", s, op);
          if (!rot_mode) begin
            chk("shift_SDL", SDL, (op == 2'b10) ? fill : 1'b0);
            chk("shift_SDR", SDR, (op == 2'b01) ? fill : 1'b0);
          end
        end
      end else begin
        chk("done_pulse", done, 1);
        chk("aborted", aborted, exp_ab);
        chk("done_s", s, 0);
        chk("done_serial", {SDL, SDR}, 0);
        chk("done_ready", cif.cmd_ready, 0);
      end
      abort = (k == abort_at);
    end
    abort = 1'b0;

    if (op == 2'b11) exp_reg = data;
    else             exp_reg = model(exp_reg, op, n, fill);
    chk("register", sr_q, exp_reg);
    if (op == 2'b11) chk("D_held", D, data);

    @(negedge CLK);
    chk("done_single", done, 0);
    chk("idle_ready", cif.cmd_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int op_r;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_cnt   = '0;
    cif.cmd_fill  = 1'b0;
    cif.cmd_data  = '0;

    // Reset state.
    repeat (2) @(negedge CLK);
    chk("rst_s", s, 0);
    chk("rst_serial", {SDL, SDR}, 0);
    chk("rst_D", D, 0);
    chk("rst_status", {busy, done, aborted}, 0);
    chk("rst_ready", cif.cmd_ready, 1);
    CLRb = 1'b1;
    @(negedge CLK);

    // Directed plan.
    run_cmd(2'b11, 0, 1'b0, 8'hA5, 0);
    chk("load_A5", sr_q, 8'hA5);
    run_cmd(2'b11, 0, 1'b0, 8'h01, 0);
    run_cmd(2'b10, 3, 1'b1, 8'h00, 0);
    if (!ROT) chk("left3_0F", sr_q, 8'h0F);
    run_cmd(2'b11, 0, 1'b0, 8'hFF, 0);
    run_cmd(2'b01, 12, 1'b0, 8'h00, 0);
    chk("right_sat_00", sr_q, 8'h00);
    run_cmd(2'b11, 0, 1'b0, 8'hF0, 0);
    run_cmd(2'b01, 6, 1'b0, 8'h00, 2);
    chk("abort2_3C", sr_q, 8'h3C);
    run_cmd(2'b01, 0, 1'b1, 8'h00, 0);
    run_cmd(2'b00, 5, 1'b1, 8'h00, 0);
    run_cmd(2'b11, 0, 1'b0, 8'h5A, 1);      // abort during LOAD ignored
    run_cmd(2'b10, 8, 1'b1, 8'h00, 9);      // abort in DONE ignored
`ifdef SHIFT_SEQ_ROTATE_EN
    run_cmd(2'b11, 0, 1'b0, 8'h81, 0);
    run_cmd(2'b10, 1, 1'b1, 8'h00, 0);
    chk("rot1_03", sr_q, 8'h03);
    run_cmd(2'b11, 0, 1'b0, 8'h81, 0);
    run_cmd(2'b10, 8, 1'b1, 8'h00, 0);
    chk("rot8_81", sr_q, 8'h81);
`endif

    // Reset mid-shift: left cnt 5, CLRb low during the 3rd cycle.
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 2'b10;
    cif.cmd_cnt   = CW'(5);
    cif.cmd_fill  = 1'b1;
    @(posedge CLK);
    #1 cif.cmd_valid = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2 CLRb = 1'b0;
    #1;
    chk("midrst_s", s, 0);
    chk("midrst_serial", {SDL, SDR}, 0);
    chk("midrst_D", D, 0);
    chk("midrst_status", {busy, done, aborted}, 0);
    chk("midrst_ready", cif.cmd_ready, 1);
    repeat (2) begin
      @(negedge CLK);
      chk("midrst_no_done", done, 0);
    end
    CLRb = 1'b1;
    @(negedge CLK);
    chk("midrst_ready_after", cif.cmd_ready, 1);
    chk("midrst_done_after", done, 0);
    run_cmd(2'b11, 0, 1'b0, 8'h3C, 0);

    // Randomized commands.
    for (int i = 0; i < 40; i++) begin
      op_r = $urandom_range(0, 3);
      run_cmd(2'(op_r), $urandom_range(0, 15), 1'($urandom), W'($urandom),
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Command sequencer for the team's 8-bit universal shift register (parallel load / shift left / shift right / hold).
- Takes one command at a time over a valid/ready handshake.
- Drives the register's mode select, serial fill inputs and parallel data for the required number of cycles, then pulses done.
- Sits between a host FSM or bus decoder and the shift register, so no upstream logic toggles the mode lines directly.

Parameters:
- WIDTH, 8, data width of the controlled shift register.
- CNT_W, 4, width of the shift-count field; counts above WIDTH saturate to WIDTH.

Ports:
- CLK  input  1  system clock, rising edge.
- CLRb  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (IDLE only).
- cmd_op  input  2  00 = hold, 01 = shift right, 10 = shift left, 11 = load.
- cmd_cnt  input  CNT_W  number of shift cycles; ignored for load and hold.
- cmd_fill  input  1  serial fill bit for shifts.
- cmd_data  input  WIDTH  parallel load value.
- abort  input  1  synchronous request to terminate the active shift.
- sr_q  input  WIDTH  current shift-register contents (used only with the optional feature).
- s  output  2  mode select to the shift register, same encoding as cmd_op.
- SDL  output  1  left-shift serial input (enters bit 0).
- SDR  output  1  right-shift serial input (enters bit WIDTH-1).
- D  output  WIDTH  parallel data to the shift register.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a command completes.
- aborted  output  1  valid with done; 1 if the command ended through abort.

Behaviour:
- Reset (CLRb low, asynchronous): state IDLE; s = 00, SDL = 0, SDR = 0, D = 0, busy = 0, done = 0, aborted = 0, cmd_ready = 1, internal counter = 0. Reset asserted mid-command discards the command with no done pulse.
- All outputs are registered. s, SDL, SDR and D change only on the CLK rising edge.
- Accept: a command is accepted on a rising edge with cmd_valid & cmd_ready. cmd_op, cmd_cnt, cmd_fill and cmd_data are captured at that edge.
- States:
  - IDLE: s = 00, cmd_ready = 1.
    - Accept op 11 -> LOAD.
    - Accept op 01/10 with cnt > 0 -> SHIFT.
    - Accept op 01/10 with cnt = 0, or op 00 -> DONE.
  - LOAD: s = 11, D = captured data, for exactly one cycle -> DONE.
  - SHIFT: s = captured op. Fill bit on SDR (right) or SDL (left); the other serial line is 0.
    - Counter loads min(cnt, WIDTH) and decrements each cycle.
    - The last shift cycle (counter = 1) -> DONE.
    - abort high in SHIFT: the current cycle is the final shift cycle -> DONE with aborted = 1.
  - DONE: s = 00, done = 1 for one cycle, cmd_ready = 0 -> IDLE.
- abort outside SHIFT is ignored.
- Latency:
  - load: s = 11 one cycle after accept, done two cycles after accept.
  - shift of N: N cycles of shift mode starting one cycle after accept; done at cycle N+1.
- Throughput: the next command is accepted in the IDLE cycle after DONE, so minimum spacing is cnt + 2 cycles.
- D holds its last loaded value outside LOAD. SDL/SDR return to 0 outside SHIFT.
- cmd_valid is not required to remain high after acceptance.

Optional Feature:
- Macro SHIFT_SEQ_ROTATE_EN.
- Defined: cmd_cnt's companion bit cmd_fill = 1 together with op 01/10 selects rotate instead of fill.
  - Each SHIFT cycle drives SDR = sr_q[0] for right, or SDL = sr_q[WIDTH-1] for left, sampled combinationally into the output register from sr_q of the previous cycle.
  - WIDTH rotates restore the original value.
- Undefined: cmd_fill is always the literal fill bit and sr_q is unused (left unconnected internally).

Test Plan:
- Reset mid-shift: left shift cnt = 5 in flight, CLRb low at cycle 3 -> all outputs 0 immediately, no done, cmd_ready = 1 after release.
- Load: cmd op 11, data 0xA5 -> s = 11 with D = 0xA5 for exactly one cycle, done one cycle later; register reads 0xA5.
- Left shift: after loading 0x01, op 10, cnt = 3, fill = 1 -> three cycles of s = 10, SDL = 1, register = 0x0F, done at cycle 4, aborted = 0.
- Right shift with saturation: load 0xFF, op 01, cnt = 12, fill = 0 -> exactly 8 shift cycles, register = 0x00, single done.
- Abort and zero count: right shift cnt = 6 with abort at the 2nd shift cycle -> 2 shifts, done with aborted = 1. Op 01 with cnt = 0 -> no shift, done one cycle after accept.
- Rotate (SHIFT_SEQ_ROTATE_EN defined): load 0x81, op 10, cnt = 1, fill = 1 -> register = 0x03. cnt = 8 -> register returns to 0x81.
